// File: rtl/bitcount_ud_n_if.sv
// Signal bundle for bitcount_ud_n: control/load inputs and count/flag outputs.
// The master drives control and load; the slave (the counter) drives the count and flags.
interface bitcount_ud_n_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             x;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  modport master (
    output en,
    output x,
    output load,
    output d,
    input  q,
    input  tc,
    input  wrap
  );

  modport slave (
    input  en,
    input  x,
    input  load,
    input  d,
    output q,
    output tc,
    output wrap
  );
endinterface

// File: rtl/bitcount_ud_n.sv
// Parametrised modulo-(MAX+1) up/down counter with load, terminal count and wrap pulse.
// Define BITCOUNT_UD_SAT_EN to saturate at 0/MAX instead of wrapping (wrap then stays 0).
module bitcount_ud_n #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = (1 << WIDTH) - 1
) (
  input logic                   clk,
  input logic                   reset,
  bitcount_ud_n_if.slave        bus
);

  localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZeroVal = '0;
  localparam logic [WIDTH-1:0] OneVal  = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             at_max, at_min;

  assign at_max = (q_q == MaxVal);
  assign at_min = (q_q == ZeroVal);

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      // Clamp rather than truncate so q can never leave 0..MAX.
      q_d = (bus.d > MaxVal) ? MaxVal : bus.d;
    end else if (bus.en) begin
      if (bus.x) begin
        if (at_max) begin
`ifdef BITCOUNT_UD_SAT_EN
          q_d = MaxVal;
`else
          q_d    = ZeroVal;
          wrap_d = 1'b1;
`endif
        end else begin
          q_d = q_q + OneVal;
        end
      end else begin
        if (at_min) begin
`ifdef BITCOUNT_UD_SAT_EN
          q_d = ZeroVal;
`else
          q_d    = MaxVal;
          wrap_d = 1'b1;
`endif
        end else begin
          q_d = q_q - OneVal;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.wrap = wrap_q;
  assign bus.tc   = bus.en & ~bus.load & ((bus.x & at_max) | (~bus.x & at_min));

endmodule

// File: tb/tb_bitcount_ud_n.sv
// Directed bench for bitcount_ud_n: a WIDTH=2 instance and a WIDTH=4/MAX=9 instance.
// Expectations follow the build: BITCOUNT_UD_SAT_EN selects the saturating sequences.
module tb_bitcount_ud_n;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bitcount_ud_n_if #(.WIDTH(2)) if2 ();
  bitcount_ud_n_if #(.WIDTH(4)) if4 ();

  bitcount_ud_n #(.WIDTH(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2)
  );

  bitcount_ud_n #(.WIDTH(4), .MAX(9)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef BITCOUNT_UD_SAT_EN
  int up_q    [5] = '{1, 2, 3, 3, 3};
  int up_wrap [5] = '{0, 0, 0, 0, 0};
  int up_tc   [5] = '{0, 0, 1, 1, 1};
`else
  int up_q    [5] = '{1, 2, 3, 0, 1};
  int up_wrap [5] = '{0, 0, 0, 1, 0};
  int up_tc   [5] = '{0, 0, 1, 0, 0};
`endif

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    if2.en = 1'b1; if2.x = 1'b1; if2.load = 1'b0; if2.d = '0;
    if4.en = 1'b0; if4.x = 1'b1; if4.load = 1'b0; if4.d = '0;

    // Reset held low across edges with en=1: nothing may move.
    for (int i = 0; i < 5; i++) begin
      #5;
      chk("rst_hold_q", 16'(if2.q), 16'd0);
      chk("rst_hold_wrap", 16'(if2.wrap), 16'd0);
    end
    #2 reset = 1'b1;

    // Up count through the boundary on the 2-bit instance.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("up_q%0d", i), 16'(if2.q), 16'(up_q[i]));
      chk($sformatf("up_wrap%0d", i), 16'(if2.wrap), 16'(up_wrap[i]));
      chk($sformatf("up_tc%0d", i), 16'(if2.tc), 16'(up_tc[i]));
    end

    // Asynchronous reset mid-count from q=2.
    if2.load = 1'b1; if2.d = 2'd2;
    tick();
    chk("mid_load_q", 16'(if2.q), 16'd2);
    if2.load = 1'b0;
    #3 reset = 1'b0;
    #1;
    chk("async_rst_q", 16'(if2.q), 16'd0);
    chk("async_rst_wrap", 16'(if2.wrap), 16'd0);
    if2.en = 1'b0;
    #2 reset = 1'b1;
    tick();
    chk("post_rst_hold", 16'(if2.q), 16'd0);

`ifdef BITCOUNT_UD_SAT_EN
    // Down from 0 saturates and keeps flagging terminal count.
    if2.en = 1'b1; if2.x = 1'b0;
    #1;
    chk("sat_dn_tc", 16'(if2.tc), 16'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_dn_q", 16'(if2.q), 16'd0);
      chk("sat_dn_wrap", 16'(if2.wrap), 16'd0);
      chk("sat_dn_tc_hold", 16'(if2.tc), 16'd1);
    end
    if2.en = 1'b0;
`else
    // Down wrap on the MAX=9 instance, then up wrap back from 9.
    if4.load = 1'b1; if4.d = 4'd1;
    tick();
    chk("dn_load1", 16'(if4.q), 16'd1);
    if4.load = 1'b0; if4.en = 1'b1; if4.x = 1'b0;
    #1;
    chk("dn_tc_q1", 16'(if4.tc), 16'd0);
    tick();
    chk("dn_q0", 16'(if4.q), 16'd0);
    chk("dn_tc_q0", 16'(if4.tc), 16'd1);
    tick();
    chk("dn_wrap_q", 16'(if4.q), 16'd9);
    chk("dn_wrap", 16'(if4.wrap), 16'd1);
    if4.x = 1'b1;
    #1;
    chk("up_tc_q9", 16'(if4.tc), 16'd1);
    tick();
    chk("up9_wrap_q", 16'(if4.q), 16'd0);
    chk("up9_wrap", 16'(if4.wrap), 16'd1);
    tick();
    chk("up9_q1", 16'(if4.q), 16'd1);
    chk("up9_wrap_clr", 16'(if4.wrap), 16'd0);
`endif

    // Load beats enable; oversize load clamps to MAX.
    if4.load = 1'b1; if4.en = 1'b1; if4.x = 1'b1; if4.d = 4'd6;
    #1;
    chk("load_tc_mask", 16'(if4.tc), 16'd0);
    tick();
    chk("load6_q", 16'(if4.q), 16'd6);
    chk("load6_wrap", 16'(if4.wrap), 16'd0);
    if4.d = 4'd15;
    tick();
    chk("load15_clamp", 16'(if4.q), 16'd9);
    if4.d = 4'd4;
    #1;
    chk("load_at_max_tc", 16'(if4.tc), 16'd0);
    tick();
    chk("load_at_max_q", 16'(if4.q), 16'd4);
    chk("load_at_max_wrap", 16'(if4.wrap), 16'd0);

    // Enable low holds; then direction flips every edge.
    if4.d = 4'd5;
    tick();
    if4.load = 1'b0; if4.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_q", 16'(if4.q), 16'd5);
      chk("hold_wrap", 16'(if4.wrap), 16'd0);
    end
    if4.en = 1'b1; if4.x = 1'b1;
    tick();
    chk("dir_q6a", 16'(if4.q), 16'd6);
    if4.x = 1'b0;
    tick();
    chk("dir_q5", 16'(if4.q), 16'd5);
    if4.x = 1'b1;
    tick();
    chk("dir_q6b", 16'(if4.q), 16'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
